dtcm_dma_engine: RTL and testbench
==================================

DTCM_DMA_ENGINE -- requirements
Module: dtcm_dma_engine

Interface
REQ-001 SHALL have parameter: LEN_WIDTH, default 13, transfer length counter width in words (covers full DTCM word space).
REQ-002 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  one-cycle request to begin a copy; sampled only in IDLE.
REQ-005 SHALL have port: abort  input  1  terminate active copy.
REQ-006 SHALL have ports: src_addr, dst_addr  input  `ADDR_WIDTH  byte addresses, sampled with start.
REQ-007 SHALL have port: len  input  LEN_WIDTH  number of 32-bit words to copy, sampled with start.
REQ-008 SHALL have ports: busy  output  1  copy in progress; done  output  1  one-cycle completion pulse; aborted  output  1  one-cycle abort pulse.
REQ-009 SHALL have ports: dma_dtcm_access  output  1; dma_dtcm_rd0_wr1  output  1 (rd=0, wr=1); dma_dtcm_addr  output  `ADDR_WIDTH; dma_dtcm_wdata  output  `DATA_WIDTH.
REQ-010 SHALL have ports: dma_dtcm_ready  input  1; dma_dtcm_rdata  input  `DATA_WIDTH; dma_dtcm_rdata_valid  input  1.

Function
REQ-011 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR, DONE.
REQ-012 IDLE: start=1 with len!=0 -> capture src/dst with addr[1:0] forced to 0, capture len into remaining counter, go RD_REQ; busy=1 from next cycle.
REQ-013 IDLE: start=1 with len=0 -> go DONE directly; no DTCM access issued.
REQ-014 RD_REQ: drive access=1, rd0_wr1=0, addr=current src, for exactly one cycle when ready=1; stay in RD_REQ while ready=0; then go RD_WAIT.
REQ-015 RD_WAIT: access=0; on rdata_valid=1 latch rdata into a 32-bit holding register, go WR; wait indefinitely otherwise.
REQ-016 WR: drive access=1, rd0_wr1=1, addr=current dst, wdata=holding register; hold all four until ready=1.
REQ-017 On WR with ready=1: src+=4, dst+=4 (modulo 2^ADDR_WIDTH, wrap silently), remaining-=1; remaining becomes 0 -> DONE, else RD_REQ.
REQ-018 Throughput with ready tied high: 3 cycles per word (RD_REQ, RD_WAIT, WR); read data latency one cycle after RD_REQ.
REQ-019 DONE: done=1 for exactly one cycle, busy=0 in that cycle, return to IDLE.
REQ-020 start while not in IDLE SHALL be ignored; sampled registers unchanged.
REQ-021 abort in any non-IDLE state SHALL take priority: next cycle IDLE, access=0, busy=0, aborted=1 for one cycle, done not asserted; a write already accepted stays committed.
REQ-022 abort in IDLE SHALL have no effect; start and abort together in IDLE: abort wins, no transfer begins, aborted not pulsed.
REQ-023 dma_dtcm_access SHALL be 0 in IDLE, RD_WAIT, DONE; rd0_wr1 and wdata SHALL be 0 whenever access=0.
REQ-024 Overlapping src/dst ranges SHALL be copied in ascending address order with no hazard protection.

Reset
REQ-025 rstn=0 SHALL asynchronously force state IDLE and all outputs, counters, address and holding registers to 0.
REQ-026 rstn asserted mid-copy SHALL discard the transfer; no done or aborted pulse after release.

Verification
REQ-027 src=0x100, dst=0x200, len=4, ready=1, DTCM preloaded 0x11..0x44 -> 4 reads then writes alternating, words at 0x200..0x20C match, done pulses on cycle 13 after start, busy high cycles 1-12.
REQ-028 len=0 start -> no access, done pulse next cycle, busy stays 0.
REQ-029 len=3, abort asserted during second RD_WAIT -> one word written to dst, access low next cycle, aborted=1 one cycle, done never asserted.
REQ-030 ready held low 5 cycles during WR -> addr/wdata/rd0_wr1 stable throughout, counter decrements once.
REQ-031 src=0xFFFFFFFC, len=2 -> second read at 0x00000000; src_addr=0x103 -> first read at 0x100.
REQ-032 start pulsed mid-transfer and rstn pulsed mid-transfer -> start ignored; after reset all outputs 0, FSM IDLE, no pulses.

Source files
------------

// File: rtl/dtcm_dma_if.sv
// DTCM access port shared by the DMA engine (master) and the tightly coupled memory (slave).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface dtcm_dma_if;
    logic                   dma_dtcm_access;
    logic                   dma_dtcm_rd0_wr1;
    logic [`ADDR_WIDTH-1:0] dma_dtcm_addr;
    logic [`DATA_WIDTH-1:0] dma_dtcm_wdata;
    logic                   dma_dtcm_ready;
    logic [`DATA_WIDTH-1:0] dma_dtcm_rdata;
    logic                   dma_dtcm_rdata_valid;

    modport master (
        output dma_dtcm_access, dma_dtcm_rd0_wr1, dma_dtcm_addr, dma_dtcm_wdata,
        input  dma_dtcm_ready, dma_dtcm_rdata, dma_dtcm_rdata_valid
    );

    modport slave (
        input  dma_dtcm_access, dma_dtcm_rd0_wr1, dma_dtcm_addr, dma_dtcm_wdata,
        output dma_dtcm_ready, dma_dtcm_rdata, dma_dtcm_rdata_valid
    );
endinterface

// File: rtl/dtcm_dma_engine.sv
// Word-by-word DTCM-to-DTCM copy engine: one read, one write per word, ascending addresses.
// Bus outputs are decoded purely from registered state, so they never depend on inputs.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dtcm_dma_engine #(
    parameter int LEN_WIDTH = 13
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   abort,
    input  logic [`ADDR_WIDTH-1:0] src_addr,
    input  logic [`ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]   len,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted,
    dtcm_dma_if.master             dtcm
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [LEN_WIDTH-1:0]   LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]   LEN_ONE   = LEN_WIDTH'(1);
    localparam logic [`ADDR_WIDTH-1:0] WORD_STEP = `ADDR_WIDTH'(4);
    localparam logic [`ADDR_WIDTH-1:0] WORD_MASK = ~(`ADDR_WIDTH'(3));

    state_t                 state_q, state_d;
    logic [`ADDR_WIDTH-1:0] src_q, src_d;
    logic [`ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]   rem_q, rem_d;
    logic [`DATA_WIDTH-1:0] hold_q, hold_d;
    logic                   aborted_q, aborted_d;

    // State and datapath registers; reset wipes any transfer in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            src_q     <= {`ADDR_WIDTH{1'b0}};
            dst_q     <= {`ADDR_WIDTH{1'b0}};
            rem_q     <= LEN_ZERO;
            hold_q    <= {`DATA_WIDTH{1'b0}};
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            hold_q    <= hold_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state logic; abort outranks everything once a copy has left IDLE.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        hold_d    = hold_q;
        aborted_d = 1'b0;
        if ((state_q != IDLE) && abort) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (len != LEN_ZERO) begin
                            src_d   = src_addr & WORD_MASK;
                            dst_d   = dst_addr & WORD_MASK;
                            rem_d   = len;
                            state_d = RD_REQ;
                        end else begin
                            state_d = DONE;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                RD_REQ: begin
                    if (dtcm.dma_dtcm_ready) begin
                        state_d = RD_WAIT;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
                RD_WAIT: begin
                    if (dtcm.dma_dtcm_rdata_valid) begin
                        hold_d  = dtcm.dma_dtcm_rdata;
                        state_d = WR;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
                WR: begin
                    if (dtcm.dma_dtcm_ready) begin
                        src_d   = src_q + WORD_STEP;
                        dst_d   = dst_q + WORD_STEP;
                        rem_d   = rem_q - LEN_ONE;
                        state_d = (rem_q == LEN_ONE) ? DONE : RD_REQ;
                    end else begin
                        state_d = WR;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state only.
    always_comb begin
        busy                  = 1'b0;
        done                  = 1'b0;
        aborted               = aborted_q;
        dtcm.dma_dtcm_access  = 1'b0;
        dtcm.dma_dtcm_rd0_wr1 = 1'b0;
        dtcm.dma_dtcm_addr    = {`ADDR_WIDTH{1'b0}};
        dtcm.dma_dtcm_wdata   = {`DATA_WIDTH{1'b0}};
        case (state_q)
            RD_REQ: begin
                busy                 = 1'b1;
                dtcm.dma_dtcm_access = 1'b1;
                dtcm.dma_dtcm_addr   = src_q;
            end
            RD_WAIT: begin
                busy = 1'b1;
            end
            WR: begin
                busy                  = 1'b1;
                dtcm.dma_dtcm_access  = 1'b1;
                dtcm.dma_dtcm_rd0_wr1 = 1'b1;
                dtcm.dma_dtcm_addr    = dst_q;
                dtcm.dma_dtcm_wdata   = hold_q;
            end
            DONE: begin
                done = 1'b1;
            end
            IDLE: begin
                busy = 1'b0;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dtcm_dma_engine.sv
// Randomized scoreboard bench for dtcm_dma_engine: a memory-level copy model predicts every bus
// access and completion pulse, and a monitor checks them as the DUT presents them.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_dtcm_dma_engine;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] src_addr = 32'd0;
    logic [31:0] dst_addr = 32'd0;
    logic [12:0] len = 13'd0;
    logic        busy, done, aborted;

    dtcm_dma_if bus ();

    dtcm_dma_engine #(.LEN_WIDTH(13)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .aborted(aborted), .dtcm(bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] dtcm_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];
    logic [31:0] exp_rd_q [$];
    logic [63:0] exp_wr_q [$];
    logic [1:0]  exp_evt_q [$];   // 2'b10 = done, 2'b01 = aborted

    int ready_pct  = 100;
    int lat_max    = 0;
    int stall_left = 0;
    int rd_cnt     = 0;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] dtcm_rd(input logic [31:0] a);
        return dtcm_mem.exists(a) ? dtcm_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic flush_expect();
        exp_rd_q.delete();
        exp_wr_q.delete();
        exp_evt_q.delete();
    endtask

    // Reference: word i of dst receives word i of src, processed in ascending order, so an
    // overlapping copy sees its own earlier writes. nrd/nwr allow modelling a cut-short copy.
    task automatic ref_copy(input logic [31:0] s_in, input logic [31:0] d_in, input int nrd, input int nwr);
        logic [31:0] s, d, v;
        s = s_in & ~32'd3;
        d = d_in & ~32'd3;
        for (int i = 0; i < nrd; i++) exp_rd_q.push_back(s + 32'(4 * i));
        for (int i = 0; i < nwr; i++) begin
            v = ref_rd(s + 32'(4 * i));
            ref_mem[d + 32'(4 * i)] = v;
            exp_wr_q.push_back({d + 32'(4 * i), v});
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        dtcm_mem[a] = v;
        ref_mem[a]  = v;
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int l);
        @(negedge clk); #1;
        start = 1'b1; src_addr = s; dst_addr = d; len = 13'(l);
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        while ((exp_evt_q.size() != 0 || busy) && c < budget) begin
            @(negedge clk); #3;
            c++;
        end
        if (c >= budget) begin
            check({name, "_timeout"}, 64'(c), 64'(budget - 1));
            flush_expect();
            @(negedge clk); #1; abort = 1'b1;
            @(negedge clk); #1; abort = 1'b0;
            repeat (3) @(negedge clk);
            flush_expect();
        end
        check({name, "_left"}, 64'(exp_rd_q.size() + exp_wr_q.size()), 64'd0);
    endtask

    task automatic run_copy(input string name, input logic [31:0] s, input logic [31:0] d, input int l);
        ref_copy(s, d, l, l);
        exp_evt_q.push_back(2'b10);
        issue(s, d, l);
        wait_idle(name, 2000);
    endtask

    // Memory slave: random ready, read data 1+lat cycles after an accepted read, optional write stall.
    initial begin
        logic        rd_pend;
        int          rd_dly;
        logic [31:0] rd_val;
        logic [64:0] cap;
        rd_pend = 1'b0; rd_dly = 0; rd_val = 32'd0; cap = 65'd0;
        bus.dma_dtcm_ready = 1'b0;
        bus.dma_dtcm_rdata = 32'd0;
        bus.dma_dtcm_rdata_valid = 1'b0;
        forever begin
            @(negedge clk);
            bus.dma_dtcm_rdata_valid = 1'b0;
            bus.dma_dtcm_rdata = 32'd0;
            if (!rstn) begin
                rd_pend = 1'b0;
                bus.dma_dtcm_ready = 1'b0;
            end else begin
                if (rd_pend) begin
                    if (rd_dly == 0) begin
                        bus.dma_dtcm_rdata_valid = 1'b1;
                        bus.dma_dtcm_rdata = rd_val;
                        rd_pend = 1'b0;
                    end else begin
                        rd_dly--;
                    end
                end
                bus.dma_dtcm_ready = ($urandom_range(99) < ready_pct);
                if (bus.dma_dtcm_access && bus.dma_dtcm_rd0_wr1 && stall_left > 0) begin
                    if (stall_left == 5)
                        cap = {bus.dma_dtcm_rd0_wr1, bus.dma_dtcm_addr, bus.dma_dtcm_wdata};
                    check("wr_stall_stable", {bus.dma_dtcm_addr, bus.dma_dtcm_wdata}, cap[63:0]);
                    check("wr_stall_dir", 64'(bus.dma_dtcm_rd0_wr1), 64'(cap[64]));
                    bus.dma_dtcm_ready = 1'b0;
                    stall_left--;
                end
                if (bus.dma_dtcm_access && bus.dma_dtcm_ready) begin
                    if (bus.dma_dtcm_rd0_wr1) begin
                        dtcm_mem[bus.dma_dtcm_addr] = bus.dma_dtcm_wdata;
                    end else begin
                        rd_pend = 1'b1;
                        rd_val  = dtcm_rd(bus.dma_dtcm_addr);
                        rd_dly  = $urandom_range(lat_max, 0);
                        rd_cnt++;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT completes a bus transfer or pulses done/aborted.
    initial begin
        logic [1:0]  evt;
        logic [63:0] wr_exp;
        logic [31:0] rd_exp;
        forever begin
            @(negedge clk); #2;
            if (!bus.dma_dtcm_access) begin
                check("idle_bus_zero", {31'd0, bus.dma_dtcm_rd0_wr1, bus.dma_dtcm_wdata}, 64'd0);
            end else if (bus.dma_dtcm_ready) begin
                if (bus.dma_dtcm_rd0_wr1) begin
                    if (exp_wr_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_write: actual addr=%0h data=%0h required none",
                                 bus.dma_dtcm_addr, bus.dma_dtcm_wdata);
                    end else begin
                        wr_exp = exp_wr_q.pop_front();
                        check("write", {bus.dma_dtcm_addr, bus.dma_dtcm_wdata}, wr_exp);
                    end
                end else begin
                    if (exp_rd_q.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_read: actual addr=%0h required none", bus.dma_dtcm_addr);
                    end else begin
                        rd_exp = exp_rd_q.pop_front();
                        check("read_addr", 64'(bus.dma_dtcm_addr), 64'(rd_exp));
                    end
                end
            end
            if (done || aborted) begin
                if (exp_evt_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_pulse: actual done=%0b aborted=%0b required none", done, aborted);
                end else begin
                    evt = exp_evt_q.pop_front();
                    check("end_pulse", 64'({done, aborted}), 64'(evt));
                end
                check("busy_at_end", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        int c, done_cyc, busy_cnt, first_busy, base;
        logic [31:0] s, d;
        int l;

        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {busy, done, aborted, bus.dma_dtcm_access, bus.dma_dtcm_rd0_wr1,
                                bus.dma_dtcm_addr == 32'd0, bus.dma_dtcm_wdata == 32'd0}, 64'b0000011);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Basic 4-word copy with exact cycle timing.
        ready_pct = 100; lat_max = 0;
        preload(32'h100, 32'h11); preload(32'h104, 32'h22);
        preload(32'h108, 32'h33); preload(32'h10C, 32'h44);
        ref_copy(32'h100, 32'h200, 4, 4);
        exp_evt_q.push_back(2'b10);
        @(negedge clk); #1;
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h200; len = 13'd4;
        done_cyc = 0; busy_cnt = 0; first_busy = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (busy) begin
                busy_cnt++;
                if (first_busy == 0) first_busy = i;
            end
            if (done) begin
                done_cyc = i;
                break;
            end
        end
        check("basic_done_cycle", 64'(done_cyc), 64'd13);
        check("basic_busy_cycles", 64'(busy_cnt), 64'd12);
        check("basic_busy_first", 64'(first_busy), 64'd1);
        wait_idle("basic", 50);
        check("basic_mem", {dtcm_rd(32'h200), dtcm_rd(32'h204)}, {32'h11, 32'h22});
        check("basic_mem_hi", {dtcm_rd(32'h208), dtcm_rd(32'h20C)}, {32'h33, 32'h44});

        // Zero-length request.
        exp_evt_q.push_back(2'b10);
        @(negedge clk); #1;
        start = 1'b1; src_addr = 32'h300; dst_addr = 32'h380; len = 13'd0;
        done_cyc = 0; busy_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done && done_cyc == 0) done_cyc = i;
        end
        check("len0_done_cycle", 64'(done_cyc), 64'd1);
        check("len0_busy", 64'(busy_cnt), 64'd0);
        wait_idle("len0", 20);

        // Abort during the second read wait: exactly one word lands.
        base = rd_cnt;
        ref_copy(32'h400, 32'h500, 2, 1);
        exp_evt_q.push_back(2'b01);
        issue(32'h400, 32'h500, 3);
        c = 0;
        while (rd_cnt < base + 2 && c < 50) begin
            @(negedge clk); #1;
            c++;
        end
        check("abort_reach_rd2", 64'(c < 50), 64'd1);
        @(negedge clk); #1; abort = 1'b1;
        @(negedge clk); #1; abort = 1'b0;
        check("abort_access_low", {busy, bus.dma_dtcm_access}, 2'b00);
        wait_idle("abort", 50);
        repeat (4) @(negedge clk);

        // Write held off for five cycles.
        stall_left = 5;
        run_copy("stall", 32'h800, 32'h880, 2);
        check("stall_consumed", 64'(stall_left), 64'd0);

        // Address wrap and misaligned start addresses.
        run_copy("wrap", 32'hFFFF_FFFC, 32'h3000, 2);
        run_copy("misalign", 32'h103, 32'h2002, 3);

        // start and abort together while idle: nothing happens.
        @(negedge clk); #1;
        start = 1'b1; abort = 1'b1; src_addr = 32'h40; dst_addr = 32'h80; len = 13'd4;
        @(negedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("start_abort_idle", {busy, aborted, done}, 64'd0);

        // A second start mid-transfer is ignored.
        ref_copy(32'h600, 32'h700, 4, 4);
        exp_evt_q.push_back(2'b10);
        issue(32'h600, 32'h700, 4);
        repeat (3) @(negedge clk);
        #1;
        start = 1'b1; src_addr = 32'h900; dst_addr = 32'hA00; len = 13'd1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_idle("start_ignored", 100);

        // Random copies with overlapping windows, back-pressure and read latency.
        for (int it = 0; it < 25; it++) begin
            ready_pct = $urandom_range(100, 40);
            lat_max   = $urandom_range(2, 0);
            s = 32'h1000 + 32'($urandom_range(63, 0) * 4) + 32'($urandom_range(3, 0));
            d = 32'h1000 + 32'($urandom_range(63, 0) * 4) + 32'($urandom_range(3, 0));
            l = $urandom_range(8, 0);
            run_copy("random", s, d, l);
        end

        // Reset mid-copy: everything clears and no pulse follows.
        ready_pct = 100; lat_max = 0;
        ref_copy(32'h5000, 32'h6000, 8, 8);
        exp_evt_q.push_back(2'b10);
        issue(32'h5000, 32'h6000, 8);
        repeat (6) @(negedge clk);
        #1;
        rstn = 1'b0;
        flush_expect();
        #1;
        check("midreset_outputs", {busy, done, aborted, bus.dma_dtcm_access, bus.dma_dtcm_rd0_wr1,
                                   bus.dma_dtcm_addr == 32'd0, bus.dma_dtcm_wdata == 32'd0}, 64'b0000011);
        repeat (2) @(negedge clk);
        #1;
        rstn = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (busy || done || aborted) busy_cnt++;
        end
        check("post_reset_quiet", 64'(busy_cnt), 64'd0);

        check("final_queues", 64'(exp_rd_q.size() + exp_wr_q.size() + exp_evt_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
